serial_mac_pe: RTL

- Responder end of the serial PE stream: consumes one 16-bit neuron/weight pair per cycle, framed by ctl[0] (first beat) and ctl[1] (last beat), and emits one 32-bit dot-product per frame with a single-cycle vld_o.
- Sits between the neuron/weight line buffers and the result writeback/compare logic.
- Two-stage pipeline (multiply, accumulate) with a frame-tracking FSM and protocol-error detection.

---
 rtl/serial_mac_pe_if.sv | 32 +++
 rtl/serial_mac_pe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_mac_pe_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mac_pe_if
//  Purpose  : Beat stream and result bundle for the serial MAC processing
//             element. The line-buffer side drives beats through the master
//             modport. The PE consumes them through the slave modport.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_mac_pe_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic [DATA_W-1:0] neuron;
    logic [DATA_W-1:0] weight;
    logic [1:0]        ctl;
    logic              vld_i;
    logic [ACC_W-1:0]  result;
    logic              vld_o;
    logic              busy;
    logic              err;

    modport master (
        output neuron, weight, ctl, vld_i,
        input  result, vld_o, busy, err
    );

    modport slave (
        input  neuron, weight, ctl, vld_i,
        output result, vld_o, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/serial_mac_pe.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mac_pe
//  Purpose  : Serial multiply-accumulate PE. Each valid beat supplies one
//             signed neuron/weight pair. The PE returns one dot-product per
//             frame, where ctl[0] marks the first beat and ctl[1] the last.
//             The datapath has two stages (multiply, then accumulate), plus a
//             frame FSM that flags protocol errors.
//  Options  : SERIAL_MAC_PE_SAT_EN - saturating accumulate. A frame that
//             saturates raises err together with its vld_o.
//  Revision : 1.0  initial release
// ============================================================================
module serial_mac_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    serial_mac_pe_if.slave   bus
);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      err_q, err_d;
    logic                      s1_vld_q, s1_vld_d;
    logic                      s1_first_q, s1_first_d;
    logic                      s1_last_q, s1_last_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [ACC_W-1:0]   result_q, result_d;
    logic                      vld_o_q, vld_o_d;

    logic                      w_proto_err;
    logic signed [PROD_W-1:0]  w_neuron_ext;
    logic signed [PROD_W-1:0]  w_weight_ext;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_add;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic                      w_sat_err;

`ifdef SERIAL_MAC_PE_SAT_EN
    logic                      sat_q, sat_d;
    logic signed [ACC_W-1:0]   w_raw_sum;
    logic                      w_ovf_pos;
    logic                      w_ovf_neg;
`endif

    // Operands are widened to the full product width, so the multiply cannot truncate.
    assign w_neuron_ext = PROD_W'($signed(bus.neuron));
    assign w_weight_ext = PROD_W'($signed(bus.weight));
    assign w_prod_ext   = ACC_W'(prod_q);

    // Frame FSM and stage-1 capture. An orphan beat (not first, while IDLE) is dropped.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        w_proto_err = 1'b0;
        s1_vld_d    = 1'b0;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        prod_d      = prod_q;
        if (bus.vld_i) begin
            if ((state_q == ST_IDLE) && !bus.ctl[0]) begin
                w_proto_err = 1'b1;
            end else begin
                // A first beat inside an open frame abandons that frame and restarts.
                w_proto_err = (state_q == ST_ACCUM) && bus.ctl[0];
                state_d     = bus.ctl[1] ? ST_IDLE : ST_ACCUM;
                busy_d      = !bus.ctl[1];
                s1_vld_d    = 1'b1;
                s1_first_d  = bus.ctl[0];
                s1_last_d   = bus.ctl[1];
                prod_d      = w_neuron_ext * w_weight_ext;
            end
        end
    end

`ifdef SERIAL_MAC_PE_SAT_EN
    // Clamp to the signed range when both addends share a sign that the sum lost.
    always_comb begin
        w_raw_sum = acc_q + w_prod_ext;
        w_ovf_pos = !acc_q[ACC_W-1] && !w_prod_ext[ACC_W-1] &&  w_raw_sum[ACC_W-1];
        w_ovf_neg =  acc_q[ACC_W-1] &&  w_prod_ext[ACC_W-1] && !w_raw_sum[ACC_W-1];
        if (w_ovf_pos) begin
            w_add = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (w_ovf_neg) begin
            w_add = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            w_add = w_raw_sum;
        end
    end
`else
    assign w_add = acc_q + w_prod_ext;
`endif

    // Stage 2: a first beat loads the accumulator and later beats add to it; the last beat publishes the result.
    always_comb begin
        acc_d      = acc_q;
        result_d   = result_q;
        vld_o_d    = 1'b0;
        w_sat_err  = 1'b0;
        w_acc_next = s1_first_q ? w_prod_ext : w_add;
`ifdef SERIAL_MAC_PE_SAT_EN
        sat_d      = sat_q;
`endif
        if (s1_vld_q) begin
            acc_d = w_acc_next;
`ifdef SERIAL_MAC_PE_SAT_EN
            sat_d = s1_first_q ? 1'b0 : (sat_q || w_ovf_pos || w_ovf_neg);
            w_sat_err = s1_last_q && sat_d;
`endif
            if (s1_last_q) begin
                result_d = w_acc_next;
                vld_o_d  = 1'b1;
            end
        end
        err_d = w_proto_err || w_sat_err;
    end

    // All state registers. Reset discards any partially accumulated frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            vld_o_q    <= 1'b0;
`ifdef SERIAL_MAC_PE_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            vld_o_q    <= vld_o_d;
`ifdef SERIAL_MAC_PE_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    assign bus.result = result_q;
    assign bus.vld_o  = vld_o_q;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;
endmodule
`default_nettype wire
